// File: rtl/unidade_controle_jogo_if.sv
// Control/status link between the game control unit and the game datapath.
// The master side is the control unit. The slave side is the datapath.
interface unidade_controle_jogo_if;
    logic fimE;
    logic fimRod;
    logic fimT;
    logic igual;
    logic enderecoIgualRodada;
    logic jogada_feita;
    logic zeraE;
    logic contaE;
    logic zeraRod;
    logic contaRod;
    logic zeraT;
    logic contaT;
    logic zeraR;
    logic registraR;

    modport master (
        input  fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita,
        output zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR
    );

    modport slave (
        output fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita,
        input  zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for the memory-sequence game.
// Every output is a pure decode of the registered state.
module unidade_controle_jogo #(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           iniciar,
    unidade_controle_jogo_if.master        dp,
    output logic                           pronto,
    output logic                           ganhou,
    output logic                           perdeu,
    output logic                           timeout,
    output logic [3:0]                     db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        INICIO_RODADA = 4'h2,
        ESPERA        = 4'h3,
        REGISTRA      = 4'h4,
        COMPARA       = 4'h5,
        PROX_JOGADA   = 4'h6,
        PROX_RODADA   = 4'h7,
        ACERTOU       = 4'hA,
        TIMEOUT       = 4'hD,
        ERROU         = 4'hE
    } estado_t;

    estado_t estado;
    estado_t prox_estado;

    always_ff @(posedge clock) begin
        if (!reset) estado <= INICIAL;
        else        estado <= prox_estado;
    end

    // A play pulse takes priority over timer expiry in ESPERA.
    always_comb begin
        prox_estado = INICIAL;
        unique case (estado)
            INICIAL:       prox_estado = iniciar ? PREPARA : INICIAL;
            PREPARA:       prox_estado = INICIO_RODADA;
            INICIO_RODADA: prox_estado = ESPERA;
            ESPERA: begin
                if (dp.jogada_feita)                prox_estado = REGISTRA;
                else if (dp.fimT && TIMEOUT_EN)     prox_estado = TIMEOUT;
                else                                prox_estado = ESPERA;
            end
            REGISTRA:      prox_estado = COMPARA;
            COMPARA: begin
                if (!dp.igual)                                  prox_estado = ERROU;
                else if (dp.enderecoIgualRodada && dp.fimRod)   prox_estado = ACERTOU;
                else if (dp.enderecoIgualRodada)                prox_estado = PROX_RODADA;
                else                                            prox_estado = PROX_JOGADA;
            end
            PROX_JOGADA:   prox_estado = ESPERA;
            PROX_RODADA:   prox_estado = INICIO_RODADA;
            ACERTOU:       prox_estado = iniciar ? PREPARA : ACERTOU;
            ERROU:         prox_estado = iniciar ? PREPARA : ERROU;
            TIMEOUT:       prox_estado = iniciar ? PREPARA : TIMEOUT;
            default:       prox_estado = INICIAL;
        endcase
    end

    always_comb begin
        dp.zeraE     = 1'b0;
        dp.contaE    = 1'b0;
        dp.zeraRod   = 1'b0;
        dp.contaRod  = 1'b0;
        dp.zeraT     = 1'b0;
        dp.contaT    = 1'b0;
        dp.zeraR     = 1'b0;
        dp.registraR = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        perdeu       = 1'b0;
        timeout      = 1'b0;
        unique case (estado)
            PREPARA: begin
                dp.zeraE   = 1'b1;
                dp.zeraRod = 1'b1;
                dp.zeraR   = 1'b1;
                dp.zeraT   = 1'b1;
            end
            INICIO_RODADA: begin
                dp.zeraE = 1'b1;
                dp.zeraT = 1'b1;
            end
            ESPERA:      dp.contaT    = 1'b1;
            REGISTRA:    dp.registraR = 1'b1;
            PROX_JOGADA: begin
                dp.contaE = 1'b1;
                dp.zeraT  = 1'b1;
            end
            PROX_RODADA: dp.contaRod = 1'b1;
            ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            TIMEOUT: begin
                pronto  = 1'b1;
                perdeu  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed self-checking bench for the game control unit, with a small
// endereco/rodada counter model standing in for the datapath.
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;
    logic       pronto2, ganhou2, perdeu2, timeout2;
    logic [3:0] db_estado2;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [3:0] end_m = '0;
    logic [3:0] rod_m = '0;

    // Output vector order: zeraE contaE zeraRod contaRod zeraT contaT zeraR registraR pronto ganhou perdeu timeout
    localparam logic [11:0] O_NONE     = 12'b0000_0000_0000;
    localparam logic [11:0] O_PREPARA  = 12'b1010_1010_0000;
    localparam logic [11:0] O_INICIO   = 12'b1000_1000_0000;
    localparam logic [11:0] O_ESPERA   = 12'b0000_0100_0000;
    localparam logic [11:0] O_REGISTRA = 12'b0000_0001_0000;
    localparam logic [11:0] O_PJOG     = 12'b0100_1000_0000;
    localparam logic [11:0] O_PROD     = 12'b0001_0000_0000;
    localparam logic [11:0] O_ACERTOU  = 12'b0000_0000_1100;
    localparam logic [11:0] O_ERROU    = 12'b0000_0000_1010;
    localparam logic [11:0] O_TIMEOUT  = 12'b0000_0000_1011;

    unidade_controle_jogo_if dpi ();
    unidade_controle_jogo_if dpi2 ();

    unidade_controle_jogo #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dp(dpi.master),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
        .db_estado(db_estado)
    );

    unidade_controle_jogo #(.TIMEOUT_EN(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .dp(dpi2.master),
        .pronto(pronto2), .ganhou(ganhou2), .perdeu(perdeu2), .timeout(timeout2),
        .db_estado(db_estado2)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        if (dpi.zeraE)       end_m <= '0;
        else if (dpi.contaE) end_m <= end_m + 4'd1;
        if (dpi.zeraRod)       rod_m <= '0;
        else if (dpi.contaRod) rod_m <= rod_m + 4'd1;
    end

    assign dpi.enderecoIgualRodada = (end_m == rod_m);
    assign dpi.fimRod              = (rod_m == 4'd15);

    assign dpi2.fimE                = dpi.fimE;
    assign dpi2.fimRod              = dpi.fimRod;
    assign dpi2.fimT                = dpi.fimT;
    assign dpi2.igual               = dpi.igual;
    assign dpi2.enderecoIgualRodada = dpi.enderecoIgualRodada;
    assign dpi2.jogada_feita        = dpi.jogada_feita;

    function automatic logic [11:0] outs();
        return {dpi.zeraE, dpi.contaE, dpi.zeraRod, dpi.contaRod, dpi.zeraT, dpi.contaT,
                dpi.zeraR, dpi.registraR, pronto, ganhou, perdeu, timeout};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [11:0] o);
        chk({tag, "_estado"}, {8'h00, db_estado}, {8'h00, st});
        chk({tag, "_saidas"}, outs(), o);
    endtask

    // One play from ESPERA: pulse jogada_feita and walk REGISTRA, COMPARA.
    task automatic jogada(input logic ig);
        dpi.igual        = ig;
        dpi.jogada_feita = 1'b1;
        step();
        dpi.jogada_feita = 1'b0;
        chk_st("registra", 4'h4, O_REGISTRA);
        step();
        chk_st("compara", 4'h5, O_NONE);
        step();
    endtask

    task automatic inicia();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_st("prepara", 4'h1, O_PREPARA);
        step();
        chk_st("inicio_rodada", 4'h2, O_INICIO);
        step();
        chk_st("espera", 4'h3, O_ESPERA);
    endtask

    initial begin
        reset            = 1'b0;
        iniciar          = 1'b0;
        dpi.fimE         = 1'b0;
        dpi.fimT         = 1'b0;
        dpi.igual        = 1'b0;
        dpi.jogada_feita = 1'b0;

        // T1: reset and start
        step();
        step();
        chk_st("t1_reset", 4'h0, O_NONE);
        reset = 1'b1;
        step();
        chk_st("t1_idle", 4'h0, O_NONE);
        inicia();
        step();
        chk_st("t1_espera_hold", 4'h3, O_ESPERA);

        // T2: full winning game
        for (int unsigned r = 0; r < 16; r++) begin
            for (int unsigned p = 0; p <= r; p++) begin
                jogada(1'b1);
                if (p < r) begin
                    chk_st("t2_prox_jogada", 4'h6, O_PJOG);
                    step();
                    chk_st("t2_espera", 4'h3, O_ESPERA);
                end else if (r < 15) begin
                    chk_st("t2_prox_rodada", 4'h7, O_PROD);
                    step();
                    chk_st("t2_inicio_rodada", 4'h2, O_INICIO);
                    step();
                    chk_st("t2_espera_r", 4'h3, O_ESPERA);
                end else begin
                    chk_st("t2_acertou", 4'hA, O_ACERTOU);
                end
            end
        end
        step();
        chk_st("t2_acertou_hold", 4'hA, O_ACERTOU);

        // T3: error on round 1, play 1
        inicia();
        jogada(1'b1);
        chk_st("t3_prox_rodada", 4'h7, O_PROD);
        step();
        step();
        chk_st("t3_espera", 4'h3, O_ESPERA);
        jogada(1'b1);
        chk_st("t3_prox_jogada", 4'h6, O_PJOG);
        step();
        jogada(1'b0);
        chk_st("t3_errou", 4'hE, O_ERROU);
        dpi.jogada_feita = 1'b1;
        step();
        dpi.jogada_feita = 1'b0;
        chk_st("t3_errou_ignora_jogada", 4'hE, O_ERROU);

        // T6b: restart from ERROU; both units stay in lockstep up to ESPERA
        inicia();
        chk("t4_nt_espera", {8'h00, db_estado2}, 12'h003);

        // T4: timeout, and the variant with timeout disabled
        dpi.fimT = 1'b1;
        step();
        dpi.fimT = 1'b0;
        chk_st("t4_timeout", 4'hD, O_TIMEOUT);
        chk("t4_nt_fica_espera", {8'h00, db_estado2}, 12'h003);
        chk("t4_nt_sem_timeout", {11'h000, timeout2}, 12'h000);
        dpi.jogada_feita = 1'b1;
        step();
        dpi.jogada_feita = 1'b0;
        chk_st("t4_timeout_hold", 4'hD, O_TIMEOUT);

        // T5: play and timer expiry in the same cycle
        inicia();
        dpi.igual        = 1'b1;
        dpi.jogada_feita = 1'b1;
        dpi.fimT         = 1'b1;
        step();
        dpi.jogada_feita = 1'b0;
        dpi.fimT         = 1'b0;
        chk_st("t5_registra", 4'h4, O_REGISTRA);
        step();
        chk_st("t5_compara", 4'h5, O_NONE);
        step();
        chk_st("t5_prox_rodada", 4'h7, O_PROD);
        step();
        step();
        chk_st("t5_espera", 4'h3, O_ESPERA);

        // T6a: reset while in COMPARA
        dpi.jogada_feita = 1'b1;
        step();
        dpi.jogada_feita = 1'b0;
        step();
        chk_st("t6_compara", 4'h5, O_NONE);
        reset = 1'b0;
        step();
        chk_st("t6_reset", 4'h0, O_NONE);
        reset = 1'b1;
        step();
        chk_st("t6_idle", 4'h0, O_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
